// File: rtl/wb_result_stage_pkg.sv
// Shared types for the registered writeback stage: load sizes, buffered entry layout
// and the canonical result-source indices.
package wb_result_stage_pkg;

    localparam int WB_XLEN_MAX = 64;

    localparam int WB_SRC_ALU   = 0;
    localparam int WB_SRC_DBUS  = 1;
    localparam int WB_SRC_PC4   = 2;
    localparam int WB_SRC_SEXT  = 3;
    localparam int WB_SRC_CSR   = 4;
    localparam int WB_SRC_SPARE = 5;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    // Data is held at the widest datapath; narrower builds use the low XLEN bits.
    typedef struct packed {
        logic [4:0]             rd;
        logic                   wen;
        logic [WB_XLEN_MAX-1:0] data;
    } wb_entry_t;

    function automatic logic writes_rd(wb_entry_t e);
        return e.wen && (e.rd != 5'd0);
    endfunction

endpackage

// File: rtl/wb_result_stage_if.sv
// Result bus between MEM stage, writeback stage and register-file write port.
// WB_FWD_EN adds the forwarding view of the youngest pending entry.
interface wb_result_stage_if #(
    parameter int XLEN = 64,
    parameter int NSRC = 6
);
    localparam int SEL_W = $clog2(NSRC);

    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [NSRC*XLEN-1:0] in_src;
    logic [4:0]           in_rd;
    logic                 in_wen;
    logic [1:0]           in_ld_size;
    logic                 in_ld_uns;
    logic [2:0]           in_ld_off;
    logic                 out_ready;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;
`ifdef WB_FWD_EN
    logic                 fwd_vld;
    logic [4:0]           fwd_rd;
    logic [XLEN-1:0]      fwd_data;
`endif

    // master: MEM stage + regfile side; slave: the writeback stage itself
    modport master (
        output in_valid, in_sel, in_src, in_rd, in_wen, in_ld_size, in_ld_uns, in_ld_off, out_ready,
`ifdef WB_FWD_EN
        input  fwd_vld, fwd_rd, fwd_data,
`endif
        input  in_ready, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_sel, in_src, in_rd, in_wen, in_ld_size, in_ld_uns, in_ld_off, out_ready,
`ifdef WB_FWD_EN
        output fwd_vld, fwd_rd, fwd_data,
`endif
        output in_ready, wb_en, wb_addr, wb_data
    );

endinterface

// File: rtl/wb_load_extract.sv
// Combinational load-data extraction: shift the bus word down by the byte offset,
// take the B/H/W/D field and sign- or zero-extend it to XLEN.
module wb_load_extract
    import wb_result_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      off,
    input  ld_size_e        size,
    input  logic            uns,
    output logic [XLEN-1:0] ext
);

    logic [63:0] raw64;
    logic [63:0] sh;
    logic [63:0] res;
    ld_size_e    sz;

    // Working at 64 bits lets bytes shifted past the top of a 32-bit word read as 0.
    assign raw64 = 64'(raw);
    assign sh    = raw64 >> {off, 3'b000};

    always_comb begin
        sz = size;
        if (XLEN == 32 && size == LD_D) sz = LD_W;
    end

    always_comb begin
        res = '0;
        unique case (sz)
            LD_B:    res = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            LD_H:    res = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            LD_W:    res = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
    end

    assign ext = res[XLEN-1:0];

endmodule

// File: rtl/wb_result_stage.sv
// Registered writeback stage: result select + load extraction feeding a 2-entry
// skid buffer that drives the register-file write port. Optional WB_FWD_EN forwarding.
module wb_result_stage
    import wb_result_stage_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NSRC     = 6,
    parameter int DBUS_IDX = WB_SRC_DBUS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    wb_result_stage_if.slave bus
);

    localparam int SEL_W = $clog2(NSRC);

    wb_entry_t       main_q, skid_q, new_e;
    logic            main_vld, skid_vld;
    logic            accept, pop;
    logic [XLEN-1:0] sel_data, ld_data, res_data;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++)
            if (bus.in_sel == SEL_W'(i)) sel_data = bus.in_src[i*XLEN +: XLEN];
    end

    wb_load_extract #(.XLEN(XLEN)) u_ld (
        .raw  (bus.in_src[DBUS_IDX*XLEN +: XLEN]),
        .off  (bus.in_ld_off),
        .size (ld_size_e'(bus.in_ld_size)),
        .uns  (bus.in_ld_uns),
        .ext  (ld_data)
    );

    assign res_data = (bus.in_sel == SEL_W'(DBUS_IDX)) ? ld_data : sel_data;

    always_comb begin
        new_e      = '0;
        new_e.rd   = bus.in_rd;
        new_e.wen  = bus.in_wen;
        new_e.data = WB_XLEN_MAX'(res_data);
    end

    // in_ready comes straight from a register so upstream never sees a comb path from out_ready.
    assign bus.in_ready = !skid_vld;
    assign accept       = bus.in_valid && !skid_vld;
    assign pop          = main_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            // accept implies skid is empty, so a popped head is refilled from the new entry
            if (accept && pop) begin
                main_q <= new_e;
            end else if (accept) begin
                if (!main_vld) begin
                    main_q   <= new_e;
                    main_vld <= 1'b1;
                end else begin
                    skid_q   <= new_e;
                    skid_vld <= 1'b1;
                end
            end else if (pop) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= 1'b0;
                end
            end
        end
    end

    assign bus.wb_en   = main_vld && writes_rd(main_q) && bus.out_ready;
    assign bus.wb_addr = main_q.rd;
    assign bus.wb_data = main_q.data[XLEN-1:0];

`ifdef WB_FWD_EN
    wb_entry_t fwd_e;

    assign fwd_e        = skid_vld ? skid_q : main_q;
    assign bus.fwd_vld  = (skid_vld || main_vld) && writes_rd(fwd_e);
    assign bus.fwd_rd   = fwd_e.rd;
    assign bus.fwd_data = fwd_e.data[XLEN-1:0];
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage: reset, select/extract, skid ordering, rd0/sel-range,
// flush, optional forwarding and reset during a stall.
module tb_wb_result_stage;

    localparam int XLEN = 64;
    localparam int NSRC = 6;

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    wb_result_stage_if #(.XLEN(XLEN), .NSRC(NSRC)) bus ();

    wb_result_stage #(.XLEN(XLEN), .NSRC(NSRC), .DBUS_IDX(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [4:0] rd, input logic wen);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
    endtask

    task automatic set_src(input int idx, input logic [63:0] val);
        bus.in_src[idx*XLEN +: XLEN] = val;
    endtask

    initial begin
        resetn         = 1'b0;
        flush          = 1'b0;
        bus.in_src     = '0;
        bus.in_ld_size = 2'd0;
        bus.in_ld_uns  = 1'b0;
        bus.in_ld_off  = 3'd0;
        bus.out_ready  = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 1'b0);

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en",    64'(bus.wb_en),    64'd0);
        chk("rst_wb_addr",  64'(bus.wb_addr),  64'd0);
        chk("rst_wb_data",  bus.wb_data,       64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // ALU result, latency 1
        @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        set_src(0, 64'h1234);
        drive(1'b1, 3'd0, 5'd5, 1'b1);
        tick();
        chk("alu_wb_en",   64'(bus.wb_en),   64'd1);
        chk("alu_wb_addr", 64'(bus.wb_addr), 64'd5);
        chk("alu_wb_data", bus.wb_data,      64'h1234);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        chk("alu_drain_en",  64'(bus.wb_en), 64'd0);
        chk("alu_hold_data", bus.wb_data,    64'h1234);

        // load extraction
        @(negedge clk);
        set_src(1, 64'h0000_0000_0080_FF00);
        bus.in_ld_off = 3'd1; bus.in_ld_size = 2'd0; bus.in_ld_uns = 1'b0;
        drive(1'b1, 3'd1, 5'd6, 1'b1);
        tick();
        chk("ldb_s_data", bus.wb_data,      64'hFFFF_FFFF_FFFF_FFFF);
        chk("ldb_s_addr", 64'(bus.wb_addr), 64'd6);
        @(negedge clk);
        bus.in_ld_uns = 1'b1;
        bus.in_rd     = 5'd7;
        tick();
        chk("ldb_u_data", bus.wb_data,      64'h0000_0000_0000_00FF);
        chk("ldb_u_addr", 64'(bus.wb_addr), 64'd7);
        @(negedge clk);
        bus.in_ld_off = 3'd0; bus.in_ld_size = 2'd1; bus.in_ld_uns = 1'b0;
        tick();
        chk("ldh_s_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FF00);
        @(negedge clk);
        bus.in_ld_off = 3'd6; bus.in_ld_size = 2'd2; bus.in_ld_uns = 1'b0;
        set_src(1, 64'h8765_4321_0000_0000);
        tick();
        chk("ldw_top_zero", bus.wb_data, 64'h0000_0000_0000_8765);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();

        // backpressure: A, B buffered, C held, FIFO release
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_src(0, 64'hA);
        drive(1'b1, 3'd0, 5'd1, 1'b1);
        tick();
        chk("bp_a_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_a_en",    64'(bus.wb_en),    64'd0);
        @(negedge clk);
        set_src(0, 64'hB); bus.in_rd = 5'd2;
        tick();
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        set_src(0, 64'hC); bus.in_rd = 5'd3;
        tick();
        chk("bp_held_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_head_a",     bus.wb_data,       64'hA);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_wr_a_en",   64'(bus.wb_en),   64'd1);
        chk("bp_wr_a_addr", 64'(bus.wb_addr), 64'd1);
        tick();
        chk("bp_wr_b_addr", 64'(bus.wb_addr),  64'd2);
        chk("bp_wr_b_data", bus.wb_data,       64'hB);
        chk("bp_b_ready",   64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_wr_c_addr", 64'(bus.wb_addr), 64'd3);
        chk("bp_wr_c_data", bus.wb_data,      64'hC);
        chk("bp_wr_c_en",   64'(bus.wb_en),   64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_empty_en", 64'(bus.wb_en), 64'd0);

        // rd0 consumes a slot without writing; out-of-range select reads 0
        @(negedge clk);
        set_src(0, 64'hBEEF);
        drive(1'b1, 3'd0, 5'd0, 1'b1);
        tick();
        chk("rd0_en",   64'(bus.wb_en), 64'd0);
        chk("rd0_head", bus.wb_data,    64'hBEEF);
        @(negedge clk);
        drive(1'b1, 3'd7, 5'd9, 1'b1);
        tick();
        chk("sel7_en",   64'(bus.wb_en),   64'd1);
        chk("sel7_addr", 64'(bus.wb_addr), 64'd9);
        chk("sel7_data", bus.wb_data,      64'd0);
        @(negedge clk);
        drive(1'b1, 3'd0, 5'd8, 1'b0);
        tick();
        chk("wen0_en", 64'(bus.wb_en), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();

        // flush while full with a concurrent valid input
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_src(0, 64'hD);
        drive(1'b1, 3'd0, 5'd10, 1'b1);
        tick();
        @(negedge clk);
        set_src(0, 64'hE); bus.in_rd = 5'd11;
        tick();
        chk("fl_full_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        set_src(0, 64'hF); bus.in_rd = 5'd12;
        tick();
        chk("fl_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("fl_no_write0", 64'(bus.wb_en), 64'd0);
        tick();
        chk("fl_no_write1", 64'(bus.wb_en), 64'd0);

`ifdef WB_FWD_EN
        // forwarding shows the youngest pending entry
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_src(0, 64'h33);
        drive(1'b1, 3'd0, 5'd3, 1'b1);
        tick();
        chk("fwd_main_data", bus.fwd_data,      64'h33);
        chk("fwd_main_vld",  64'(bus.fwd_vld),  64'd1);
        @(negedge clk);
        set_src(0, 64'h44);
        tick();
        chk("fwd_skid_data", bus.fwd_data,      64'h44);
        chk("fwd_skid_rd",   64'(bus.fwd_rd),   64'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
`endif

        // reset during a stall drops everything
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_src(0, 64'h55);
        drive(1'b1, 3'd0, 5'd20, 1'b1);
        tick();
        @(negedge clk);
        bus.in_rd = 5'd21;
        tick();
        @(negedge clk);
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        tick();
        @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rs_en",    64'(bus.wb_en),    64'd0);
        chk("rs_ready", 64'(bus.in_ready), 64'd1);
        chk("rs_data",  bus.wb_data,       64'd0);
        tick();
        chk("rs_en2",   64'(bus.wb_en),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
